mips_cpu_run_controller: RTL

- Synthesizable run-control harness for one mips_cpu_harvard instance.
- Sequences CPU reset and clock enable, waits for the CPU to raise active, then counts run cycles until active drops or a timeout fires.
- Captures register_v0 one cycle after halt and reports a status code.
- Replaces fixed-timeout bench logic with a parametrised, reusable block used by both the simulation top and the FPGA wrapper.

---
 rtl/mips_run_pkg.sv | 21 ++
 rtl/mips_cpu_run_controller.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/mips_run_pkg.sv
// Shared types for the MIPS CPU run controller: FSM state encoding and
// the status codes reported to the simulation top and the FPGA wrapper.
package mips_run_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CPU_RST  = 3'd1,
    WAIT_ACT = 3'd2,
    RUN      = 3'd3,
    SETTLE   = 3'd4,
    DONE     = 3'd5
  } run_state_t;

  typedef enum logic [1:0] {
    HALT_OK  = 2'd0,
    TIMEOUT  = 2'd1,
    NO_START = 2'd2,
    MISMATCH = 2'd3
  } run_status_t;

endpackage

// File: rtl/mips_cpu_run_controller.sv
// Run-control harness for one mips_cpu_harvard instance.
// On start it holds the CPU in reset for RESET_CYCLES, waits up to
// START_TIMEOUT cycles for cpu_active, counts run cycles until the CPU
// halts or TIMEOUT_CYCLES expire, lets the CPU settle one edge, then
// captures register_v0 and pulses done with a status code.
// Optional build macro MIPS_RUN_CHECK_EN: compare the captured v0 against
// expected_v0 on a normal halt and report MISMATCH when they differ.
module mips_cpu_run_controller
  import mips_run_pkg::*;
#(
  parameter int unsigned RESET_CYCLES   = 1,
  parameter int unsigned START_TIMEOUT  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 100,
  parameter int unsigned CYCLE_W        = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [31:0]        expected_v0,
  input  logic               cpu_active,
  input  logic [31:0]        cpu_register_v0,
  output logic               cpu_reset,
  output logic               cpu_clk_enable,
  output logic               busy,
  output logic               done,
  output logic [1:0]         status,
  output logic [31:0]        result_v0,
  output logic [CYCLE_W-1:0] cycle_count
);

  // Terminal counter values; the comparisons against these keep cnt from wrapping.
  localparam logic [CYCLE_W-1:0] RST_LAST = CYCLE_W'(RESET_CYCLES - 1);
  localparam logic [CYCLE_W-1:0] ACT_LAST = CYCLE_W'(START_TIMEOUT - 1);
  localparam logic [CYCLE_W-1:0] RUN_LAST = CYCLE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CYCLE_W-1:0] RUN_MAX  = CYCLE_W'(TIMEOUT_CYCLES);

  run_state_t          state;
  logic [CYCLE_W-1:0]  cnt;
  logic [CYCLE_W-1:0]  run_len;
  run_status_t         halt_status;

`ifdef MIPS_RUN_CHECK_EN
  // A normal halt is downgraded to MISMATCH when v0 disagrees with the reference.
  assign halt_status = (cpu_register_v0 != expected_v0) ? MISMATCH : HALT_OK;
`else
  // Without the check, expected_v0 is deliberately left unconnected.
  logic unused_expected_v0;
  assign unused_expected_v0 = ^expected_v0;
  assign halt_status        = HALT_OK;
`endif

  // Run-control FSM with registered CPU controls, handshake and result capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      cnt            <= '0;
      run_len        <= '0;
      cpu_reset      <= 1'b1;
      cpu_clk_enable <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      status         <= HALT_OK;
      result_v0      <= '0;
      cycle_count    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state          <= CPU_RST;
            cnt            <= '0;
            busy           <= 1'b1;
            cpu_reset      <= 1'b1;
            cpu_clk_enable <= 1'b1;
          end
        end

        CPU_RST: begin
          if (cnt == RST_LAST) begin
            state     <= WAIT_ACT;
            cnt       <= '0;
            cpu_reset <= 1'b0;
          end else begin
            cnt <= cnt + CYCLE_W'(1);
          end
        end

        WAIT_ACT: begin
          if (cpu_active) begin
            state <= RUN;
            cnt   <= '0;
          end else if (cnt == ACT_LAST) begin
            state          <= DONE;
            done           <= 1'b1;
            cpu_clk_enable <= 1'b0;
            status         <= NO_START;
            result_v0      <= cpu_register_v0;
            cycle_count    <= '0;
          end else begin
            cnt <= cnt + CYCLE_W'(1);
          end
        end

        RUN: begin
          cnt <= cnt + CYCLE_W'(1);
          // The halt check comes first so a halt on the timeout cycle wins.
          if (!cpu_active) begin
            state   <= SETTLE;
            run_len <= cnt;
          end else if (cnt == RUN_LAST) begin
            state          <= DONE;
            done           <= 1'b1;
            cpu_clk_enable <= 1'b0;
            status         <= TIMEOUT;
            result_v0      <= cpu_register_v0;
            cycle_count    <= RUN_MAX;
          end
        end

        SETTLE: begin
          // One extra enabled edge lets the CPU retire its last write before v0 is sampled.
          state          <= DONE;
          done           <= 1'b1;
          cpu_clk_enable <= 1'b0;
          status         <= halt_status;
          result_v0      <= cpu_register_v0;
          cycle_count    <= run_len;
        end

        DONE: begin
          // cpu_reset stays low during DONE so the halted CPU remains inspectable.
          state     <= IDLE;
          busy      <= 1'b0;
          cpu_reset <= 1'b1;
        end

        default: begin
          state          <= IDLE;
          busy           <= 1'b0;
          cpu_reset      <= 1'b1;
          cpu_clk_enable <= 1'b0;
        end
      endcase
    end
  end

endmodule
